// File: rtl/prgrm_seqncr.sv
// Program sequencer: PC register with increment, absolute/relative branch,
// and a small return-address stack for Call/Ret with sticky error flags.
module prgrm_seqncr #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned STK_DEPTH = 4,
  parameter int unsigned RESET_VEC = 0
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             Stall,
  input  logic                             Incrmnt_PC,
  input  logic                             Ld_Brnch_Addr,
  input  logic                             Brnch_Rel,
  input  logic                             Call,
  input  logic                             Ret,
  input  logic                             Clr_Err,
  input  logic [ADDR_W-1:0]                Imm_Addr,
  output logic [ADDR_W-1:0]                PC,
  output logic [$clog2(STK_DEPTH+1)-1:0]   Stk_Cnt,
  output logic                             Stk_Full,
  output logic                             Stk_Empty,
  output logic                             Stk_Ovf,
  output logic                             Stk_Unf
);

  localparam int unsigned CNT_W = $clog2(STK_DEPTH + 1);
  localparam int unsigned IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [ADDR_W-1:0] stk_q [STK_DEPTH];
  logic [ADDR_W-1:0] stk_d [STK_DEPTH];

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target;
  logic              full;
  logic              empty;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;

  assign pc_inc   = pc_q + 1'b1;
  // Two's-complement add wraps identically for a signed offset.
  assign target   = Brnch_Rel ? (pc_q + Imm_Addr) : Imm_Addr;
  assign full     = (cnt_q == CNT_W'(STK_DEPTH));
  assign empty    = (cnt_q == '0);
  assign push_idx = IDX_W'(cnt_q);
  assign pop_idx  = IDX_W'(cnt_q - 1'b1);

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    stk_d = stk_q;
    // Clear first so a same-cycle error event below wins.
    ovf_d = Clr_Err ? 1'b0 : ovf_q;
    unf_d = Clr_Err ? 1'b0 : unf_q;
    if (!Stall) begin
      if (Ret) begin
        if (!empty) begin
          pc_d  = stk_q[pop_idx];
          cnt_d = cnt_q - 1'b1;
        end else begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end
      end else if (Call) begin
        pc_d = target;
        if (!full) begin
          stk_d[push_idx] = pc_inc;
          cnt_d           = cnt_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (Ld_Brnch_Addr) begin
        pc_d = target;
      end else if (Incrmnt_PC) begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc_q  <= ADDR_W'(RESET_VEC);
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      stk_q <= '{default: '0};
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      stk_q <= stk_d;
    end
  end

  assign PC        = pc_q;
  assign Stk_Cnt   = cnt_q;
  assign Stk_Full  = full;
  assign Stk_Empty = empty;
  assign Stk_Ovf   = ovf_q;
  assign Stk_Unf   = unf_q;

endmodule
